// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way ring round-robin arbiter.
package ring_arb_pkg;

   localparam int N_REQ = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RECOVER = 2'd2
   } state_t;

   function automatic logic [N_REQ-1:0] rotl(input logic [N_REQ-1:0] v);
      return {v[N_REQ-2:0], v[N_REQ-1]};
   endfunction

endpackage

// File: rtl/ring_priority_pick.sv
// Combinational priority pick: first set request at or after the one-hot pointer, wrapping 3->0.
module ring_priority_pick
   import ring_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] ptr,
   output logic [N_REQ-1:0] pick,
   output logic [1:0]       pick_idx,
   output logic             valid
);

   logic [1:0]         ptr_idx;
   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [1:0]         off;
   logic               found;

   always_comb begin
      ptr_idx = 2'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ptr[i]) ptr_idx = 2'(i);
      end

      // Rotate right by the pointer index so the highest-priority requester lands on bit 0.
      req_dbl = {req, req};
      req_rot = req_dbl[ptr_idx +: N_REQ];

      found = 1'b0;
      off   = 2'd0;
      for (int j = 0; j < N_REQ; j++) begin
         if (req_rot[j] && !found) begin
            found = 1'b1;
            off   = 2'(j);
         end
      end

      pick_idx = off + ptr_idx;
      pick     = found ? (4'b0001 << pick_idx) : 4'b0000;
      valid    = found;
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Four-way round-robin arbiter with a one-hot rotating priority pointer, hold limit and recovery cycle.
//   state   | meaning
//   IDLE    | no owner; pick next requester in ring order
//   HOLD    | grant held until done, request drop, or hold limit
//   RECOVER | single dead cycle between owners
module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       grant_id,
   output logic             busy,
   output logic             timeout
);

   state_t           state, state_nxt;
   logic [N_REQ-1:0] ptr, ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [N_REQ-1:0] grant_nxt;
   logic [1:0]       grant_id_nxt;
   logic             timeout_nxt;

   logic [N_REQ-1:0] pick;
   logic [1:0]       pick_idx;
   logic             pick_valid;
   logic             rel_done, rel_req, rel_lim;

   ring_priority_pick u_pick (
      .req      (req),
      .ptr      (ptr),
      .pick     (pick),
      .pick_idx (pick_idx),
      .valid    (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 4'b0001;
         cnt      <= '0;
         grant    <= '0;
         grant_id <= 2'd0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         grant    <= grant_nxt;
         grant_id <= grant_id_nxt;
         busy     <= |grant_nxt;
         timeout  <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      cnt_nxt      = cnt;
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      timeout_nxt  = 1'b0;
      rel_done     = done[grant_id];
      rel_req      = !req[grant_id];
      rel_lim      = (cnt == CNT_W'(HOLD_MAX - 1));

      case (state)
         IDLE: begin
            grant_nxt = '0;
            if (pick_valid) begin
               grant_nxt    = pick;
               grant_id_nxt = pick_idx;
               cnt_nxt      = '0;
               state_nxt    = HOLD;
            end
         end
         HOLD: begin
            cnt_nxt = cnt + 1'b1;
            if (rel_done || rel_req || rel_lim) begin
               grant_nxt   = '0;
               cnt_nxt     = '0;
               ptr_nxt     = rotl(grant);
               // A forced release is flagged only when nothing else would have released the grant.
               timeout_nxt = rel_lim && !rel_done && !rel_req;
               state_nxt   = RECOVER;
            end
         end
         RECOVER: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
         default: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
